// File: rtl/lilme_job_arbiter.sv
// Round-robin owner of a single LilME engine: picks one requester, issues its opcode
// for one cycle, holds the grant while the engine is busy (or until the watchdog fires).
module lilme_job_arbiter #(
  parameter int NREQ    = 2,
  parameter int OPW     = 3,
  parameter int TIMEOUT = 255
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NREQ-1:0]      req,
  input  logic [NREQ*OPW-1:0]  req_op,
  output logic [NREQ-1:0]      grant,
  output logic [NREQ-1:0]      done,
  output logic                 done_err,
  output logic [OPW-1:0]       ME_opcode,
  input  logic                 me_busy,
  output logic                 arb_busy,
  output logic                 timeout_err
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_RUN, S_DONE} state_t;

  state_t          state_q, state_d;
  logic [IW-1:0]   ptr_q, ptr_d;
  logic [IW-1:0]   gidx_q, gidx_d;
  logic [OPW-1:0]  op_q, op_d;
  logic [7:0]      run_cnt_q, run_cnt_d;
  logic [NREQ-1:0] grant_q, grant_d;
  logic [NREQ-1:0] done_q, done_d;
  logic            done_err_q, done_err_d;
  logic [OPW-1:0]  opcode_q, opcode_d;
  logic            timeout_err_q, timeout_err_d;

  logic            win_found;
  logic [IW-1:0]   win_idx;
  logic [IW-1:0]   cand;
  logic [OPW-1:0]  win_op;
  logic            timeout_hit;

  function automatic logic [NREQ-1:0] onehot(input logic [IW-1:0] idx);
    onehot = '0;
    onehot[idx] = 1'b1;
  endfunction

  // Scan from the requester after the last owner, wrapping, so the last owner goes last.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int k = 1; k <= NREQ; k++) begin
      cand = IW'((int'(ptr_q) + k) % NREQ);
      if (!win_found && req[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
    win_op = req_op[win_idx*OPW +: OPW];
  end

  // run_cnt holds completed RUN cycles; the watchdog fires when this cycle would reach TIMEOUT.
  assign timeout_hit = ({1'b0, run_cnt_q} + 9'd1) >= 9'(TIMEOUT);

  always_comb begin
    state_d       = state_q;
    ptr_d         = ptr_q;
    gidx_d        = gidx_q;
    op_d          = op_q;
    run_cnt_d     = run_cnt_q;
    grant_d       = grant_q;
    done_d        = '0;
    done_err_d    = 1'b0;
    opcode_d      = '0;
    timeout_err_d = timeout_err_q;
    case (state_q)
      S_IDLE: begin
        grant_d = '0;
        if (win_found) begin
          gidx_d  = win_idx;
          op_d    = win_op;
          grant_d = onehot(win_idx);
          if (win_op != '0) begin
            opcode_d = win_op;
            state_d  = S_ISSUE;
          end else begin
            done_d  = onehot(win_idx);
            state_d = S_DONE;
          end
        end
      end
      S_ISSUE: begin
        run_cnt_d = '0;
        state_d   = S_RUN;
      end
      S_RUN: begin
        run_cnt_d = (run_cnt_q == 8'(TIMEOUT)) ? run_cnt_q : run_cnt_q + 8'd1;
        if (!me_busy && run_cnt_q != '0) begin
          done_d  = grant_q;
          state_d = S_DONE;
        end else if (me_busy && timeout_hit) begin
          done_d        = grant_q;
          done_err_d    = 1'b1;
          timeout_err_d = 1'b1;
          state_d       = S_DONE;
        end
      end
      default: begin
        grant_d = '0;
        ptr_d   = gidx_q;
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= S_IDLE;
      ptr_q         <= IW'(NREQ - 1);
      grant_q       <= '0;
      done_q        <= '0;
      done_err_q    <= 1'b0;
      opcode_q      <= '0;
      timeout_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      ptr_q         <= ptr_d;
      grant_q       <= grant_d;
      done_q        <= done_d;
      done_err_q    <= done_err_d;
      opcode_q      <= opcode_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  // Job context is always rewritten before it is consumed, so it carries no reset.
  always_ff @(posedge clk) begin
    gidx_q    <= gidx_d;
    op_q      <= op_d;
    run_cnt_q <= run_cnt_d;
  end

  assign grant       = grant_q;
  assign done        = done_q;
  assign done_err    = done_err_q;
  assign ME_opcode   = opcode_q;
  assign arb_busy    = (state_q != S_IDLE);
  assign timeout_err = timeout_err_q;

endmodule

// File: tb/tb_lilme_job_arbiter.sv
// Bench for lilme_job_arbiter: job-level reference model checked every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_lilme_job_arbiter;

  localparam int NREQ    = 2;
  localparam int OPW     = 3;
  localparam int TIMEOUT = 8;

  logic                clk = 1'b0;
  logic                reset = 1'b1;
  logic [NREQ-1:0]     req = '0;
  logic [NREQ*OPW-1:0] req_op = '0;
  logic                me_busy = 1'b0;
  logic [NREQ-1:0]     grant;
  logic [NREQ-1:0]     done;
  logic                done_err;
  logic [OPW-1:0]      ME_opcode;
  logic                arb_busy;
  logic                timeout_err;

  int checks = 0;
  int errors = 0;

  lilme_job_arbiter #(.NREQ(NREQ), .OPW(OPW), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset), .req(req), .req_op(req_op),
    .grant(grant), .done(done), .done_err(done_err), .ME_opcode(ME_opcode),
    .me_busy(me_busy), .arb_busy(arb_busy), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Job-level model: phase 0 waiting, 1 opcode cycle, 2 engine running, 3 completion cycle.
  int              m_phase;
  int              m_owner;
  int              m_ptr;
  int              m_run;
  logic [OPW-1:0]  m_op;
  bit              m_tout;
  bit              m_sticky;

  task automatic m_reset();
    m_phase = 0; m_owner = 0; m_ptr = NREQ - 1; m_run = 0;
    m_op = '0; m_tout = 0; m_sticky = 0;
  endtask

  task automatic m_step();
    int idx;
    int found;
    case (m_phase)
      0: begin
        found = -1;
        for (int k = 1; k <= NREQ; k++) begin
          idx = (m_ptr + k) % NREQ;
          if (found < 0 && req[idx]) found = idx;
        end
        if (found >= 0) begin
          m_owner = found;
          m_op    = req_op[found*OPW +: OPW];
          m_tout  = 0;
          m_phase = (m_op != '0) ? 1 : 3;
        end
      end
      1: begin m_phase = 2; m_run = 0; end
      2: begin
        m_run++;
        if (!me_busy && m_run >= 2) m_phase = 3;
        else if (me_busy && m_run >= TIMEOUT) begin
          m_phase = 3; m_tout = 1; m_sticky = 1;
        end
      end
      default: begin m_ptr = m_owner; m_phase = 0; end
    endcase
  endtask

  function automatic logic [NREQ-1:0] owner_vec();
    logic [NREQ-1:0] one = 1;
    return one << m_owner;
  endfunction

  initial begin : scoreboard
    m_reset();
    fork
      forever begin
        @(posedge clk or posedge reset);
        if (reset) m_reset();
        else m_step();
      end
      forever begin
        @(negedge clk);
        chk("grant",       32'(grant),       32'((m_phase != 0) ? owner_vec() : '0));
        chk("done",        32'(done),        32'((m_phase == 3) ? owner_vec() : '0));
        chk("done_err",    32'(done_err),    32'(m_phase == 3 && m_tout));
        chk("ME_opcode",   32'(ME_opcode),   32'((m_phase == 1) ? m_op : '0));
        chk("arb_busy",    32'(arb_busy),    32'(m_phase != 0));
        chk("timeout_err", 32'(timeout_err), 32'(m_sticky));
      end
    join_none
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_done(input string name, input int max, output int n);
    n = 0;
    while (done == '0 && n < max) begin tick(); n++; end
    chk(name, 32'(done != '0), 32'd1);
  endtask

  task automatic wait_idle(input string name, input int max);
    int n = 0;
    while (arb_busy && n < max) begin tick(); n++; end
    chk(name, 32'(arb_busy), 32'd0);
  endtask

  initial begin : stimulus
    int n;
    int gap;
    logic [NREQ-1:0] exp_g;

    repeat (3) tick();
    reset = 1'b0;
    tick();
    chk("rst_grant", 32'(grant), 32'd0);
    chk("rst_busy",  32'(arb_busy), 32'd0);
    chk("rst_terr",  32'(timeout_err), 32'd0);

    // reset in the middle of a running job
    req = 2'b01; req_op = 6'b000_001;
    tick();
    chk("t1_grant", 32'(grant), 32'h1);
    me_busy = 1'b1;
    tick(); tick();
    reset = 1'b1;
    #1;
    chk("t1_rst_grant", 32'(grant), 32'd0);
    chk("t1_rst_op",    32'(ME_opcode), 32'd0);
    chk("t1_rst_busy",  32'(arb_busy), 32'd0);
    me_busy = 1'b0; req = 2'b11; req_op = 6'b101_101;
    tick();
    reset = 1'b0;
    tick();
    chk("t1_first_grant", 32'(grant), 32'h1);
    chk("t1_first_op",    32'(ME_opcode), 32'h5);

    // round robin with both requesters held
    exp_g = 2'b01;
    for (int j = 0; j < 4; j++) begin
      if (j > 0) begin
        n = 0;
        while (grant != '0 && n < 20) begin tick(); n++; end
        gap = 0;
        while (grant == '0 && gap < 20) begin tick(); gap++; end
        chk("t3_gap", 32'(gap), 32'd1);
      end
      chk("t3_grant", 32'(grant), 32'(exp_g));
      exp_g = ~exp_g;
    end
    req = '0;
    wait_idle("t3_idle", 20);

    // single job with a 4-cycle busy window
    req = 2'b01; req_op = 6'b000_010;
    tick();
    chk("t2_issue_op", 32'(ME_opcode), 32'h2);
    req_op = 6'b000_111;
    tick();
    chk("t2_run_op", 32'(ME_opcode), 32'd0);
    me_busy = 1'b1;
    repeat (4) tick();
    me_busy = 1'b0;
    chk("t2_no_early_done", 32'(done), 32'd0);
    tick();
    chk("t2_done",     32'(done), 32'h1);
    chk("t2_done_err", 32'(done_err), 32'd0);
    req = '0;
    tick();
    chk("t2_done_pulse", 32'(done), 32'd0);
    chk("t2_grant_off",  32'(grant), 32'd0);

    // watchdog with the engine stuck busy
    req = 2'b01; req_op = 6'b000_011; me_busy = 1'b1;
    tick();
    chk("t4_grant", 32'(grant), 32'h1);
    wait_done("t4_wait", 20, n);
    chk("t4_latency",  32'(n), 32'd9);
    chk("t4_done",     32'(done), 32'h1);
    chk("t4_done_err", 32'(done_err), 32'd1);
    chk("t4_terr",     32'(timeout_err), 32'd1);
    req = '0; me_busy = 1'b0;
    repeat (3) tick();
    chk("t4_terr_sticky", 32'(timeout_err), 32'd1);
    chk("t4_err_clear",   32'(done_err), 32'd0);

    // null opcode goes straight to completion
    req = 2'b10; req_op = 6'b000_000;
    wait_done("t5_wait", 4, n);
    chk("t5_done",     32'(done), 32'h2);
    chk("t5_op",       32'(ME_opcode), 32'd0);
    chk("t5_done_err", 32'(done_err), 32'd0);
    req = '0;
    wait_idle("t5_idle", 10);

    // owner drops req mid-job, other requester waits
    req = 2'b01; req_op = 6'b110_001;
    tick();
    chk("t6_grant0", 32'(grant), 32'h1);
    tick();
    me_busy = 1'b1; req = 2'b10;
    tick(); tick();
    me_busy = 1'b0;
    wait_done("t6_wait", 10, n);
    chk("t6_done0", 32'(done), 32'h1);
    tick(); tick();
    chk("t6_grant1", 32'(grant), 32'h2);
    chk("t6_op1",    32'(ME_opcode), 32'h6);
    req = '0;
    wait_idle("t6_idle", 20);

    tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
